// File: rtl/data_mem_ctrl.sv
// Data-memory access controller for the MA stage of the RV32I pipeline.
// Formats byte/half/word accesses, runs one req/ack bus transaction and stalls the pipeline until it finishes.
module data_mem_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_ma_read,
    input  logic        i_ma_write,
    input  logic [31:0] i_ma_addr,
    input  logic [31:0] i_ma_wdata,
    input  logic [2:0]  i_ma_funct3,
    output logic [31:0] o_ma_rdata,
    output logic        o_data_ready,
    output logic        o_misaligned,
    output logic        o_bus_err,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [3:0]  o_mem_be,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_err,
    output logic [1:0]  dbg_state
);

    // Handshake: o_mem_req stays high from entry into ACCESS until the cycle
    // i_mem_ack is sampled (or the timeout fires); the MA inputs are held
    // stable by the stall (o_data_ready low) for the whole transaction.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    state_t      state;
    logic [15:0] wait_cnt;

    logic        req_any;
    logic        size_b;
    logic        size_h;
    logic        size_w;
    logic        illegal;
    logic        misaligned;
    logic [31:0] lane_word;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_fmt;

    assign req_any = i_ma_read | i_ma_write;
    assign size_b  = (i_ma_funct3[1:0] == 2'b00);
    assign size_h  = (i_ma_funct3[1:0] == 2'b01);
    assign size_w  = (i_ma_funct3 == 3'b010);

    // Unsigned variants (funct3[2]) only exist for loads; 011/110/111 are unused encodings.
    assign illegal = (i_ma_read & i_ma_write)
                   | (i_ma_funct3 == 3'b011)
                   | (i_ma_funct3 == 3'b110)
                   | (i_ma_funct3 == 3'b111)
                   | (i_ma_funct3[2] & i_ma_write);

    assign misaligned = (size_h & i_ma_addr[0]) | (size_w & (i_ma_addr[1:0] != 2'b00));

    assign o_mem_addr = {i_ma_addr[31:2], 2'b00};

    always_comb begin
        o_mem_be    = 4'b1111;
        o_mem_wdata = i_ma_wdata;
        if (size_b) begin
            o_mem_be    = 4'b0001 << i_ma_addr[1:0];
            o_mem_wdata = {4{i_ma_wdata[7:0]}};
        end else if (size_h) begin
            o_mem_be    = 4'b0011 << {i_ma_addr[1], 1'b0};
            o_mem_wdata = {2{i_ma_wdata[15:0]}};
        end
    end

    // Load path: shift the addressed lane down to bit 0, then extend.
    assign lane_word = i_mem_rdata >> {i_ma_addr[1:0], 3'b000};
    assign lane_byte = lane_word[7:0];
    assign lane_half = lane_word[15:0];

    always_comb begin
        load_fmt = i_mem_rdata;
        case (i_ma_funct3)
            3'b000:  load_fmt = {{24{lane_byte[7]}}, lane_byte};
            3'b001:  load_fmt = {{16{lane_half[15]}}, lane_half};
            3'b100:  load_fmt = {24'd0, lane_byte};
            3'b101:  load_fmt = {16'd0, lane_half};
            default: load_fmt = i_mem_rdata;
        endcase
    end

    assign o_data_ready = (state == DONE) || ((state == IDLE) && !req_any);
    assign dbg_state    = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            wait_cnt     <= 16'd0;
            o_mem_req    <= 1'b0;
            o_mem_we     <= 1'b0;
            o_ma_rdata   <= 32'd0;
            o_misaligned <= 1'b0;
            o_bus_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_any) begin
                        if (illegal) begin
                            state     <= DONE;
                            o_bus_err <= 1'b1;
                        end else if (misaligned) begin
                            state        <= DONE;
                            o_misaligned <= 1'b1;
                        end else begin
                            state     <= ACCESS;
                            wait_cnt  <= 16'd0;
                            o_mem_req <= 1'b1;
                            o_mem_we  <= i_ma_write;
                        end
                    end
                end
                ACCESS: begin
                    if (i_mem_ack) begin
                        state     <= DONE;
                        o_mem_req <= 1'b0;
                        o_mem_we  <= 1'b0;
                        if (i_mem_err) begin
                            o_bus_err <= 1'b1;
                        end else if (i_ma_read) begin
                            o_ma_rdata <= load_fmt;
                        end
                    end else if (wait_cnt == TIMEOUT_LAST) begin
                        state     <= DONE;
                        o_mem_req <= 1'b0;
                        o_mem_we  <= 1'b0;
                        o_bus_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                DONE: begin
                    state        <= IDLE;
                    o_misaligned <= 1'b0;
                    o_bus_err    <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    o_mem_req <= 1'b0;
                    o_mem_we  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: a bus responder driven per access, with expected
// load results queued at request time and popped when the access completes.
module tb_data_mem_ctrl;

    logic        clk;
    logic        rst;
    logic        i_ma_read;
    logic        i_ma_write;
    logic [31:0] i_ma_addr;
    logic [31:0] i_ma_wdata;
    logic [2:0]  i_ma_funct3;
    logic [31:0] o_ma_rdata;
    logic        o_data_ready;
    logic        o_misaligned;
    logic        o_bus_err;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [3:0]  o_mem_be;
    logic [31:0] o_mem_wdata;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;
    logic        i_mem_err;
    logic [1:0]  dbg_state;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];
    logic [31:0] model_rdata = 32'd0;

    // observations from the most recent access
    int          obs_stall;
    int          obs_reqc;
    int          obs_first_req;
    logic [3:0]  obs_be;
    logic        obs_we;
    logic [31:0] obs_wdata;
    logic [31:0] obs_addr;
    logic        obs_mis;
    logic        obs_berr;
    logic [31:0] obs_rdata;
    logic        obs_done;

    data_mem_ctrl #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .i_ma_read(i_ma_read), .i_ma_write(i_ma_write), .i_ma_addr(i_ma_addr),
        .i_ma_wdata(i_ma_wdata), .i_ma_funct3(i_ma_funct3),
        .o_ma_rdata(o_ma_rdata), .o_data_ready(o_data_ready),
        .o_misaligned(o_misaligned), .o_bus_err(o_bus_err),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_be(o_mem_be), .o_mem_wdata(o_mem_wdata),
        .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata), .i_mem_err(i_mem_err),
        .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        case (addr[1:0])
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = addr[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'd0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'd0, h};
            default: return word;
        endcase
    endfunction

    // driver: issues one request and acts as the bus; waits<0 means never ack
    task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] mrdata, input logic merr, input int waits);
        @(posedge clk); #1;
        i_ma_read = rd; i_ma_write = wr; i_ma_funct3 = f3;
        i_ma_addr = addr; i_ma_wdata = wdata;
        obs_stall = 0; obs_reqc = 0; obs_first_req = -1; obs_done = 1'b0;
        obs_be = 4'd0; obs_we = 1'b0; obs_wdata = 32'd0; obs_addr = 32'd0;
        obs_mis = 1'b0; obs_berr = 1'b0; obs_rdata = 32'd0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            i_mem_ack = 1'b0; i_mem_err = 1'b0;
            if (o_data_ready) begin
                obs_mis = o_misaligned; obs_berr = o_bus_err;
                obs_rdata = o_ma_rdata; obs_done = 1'b1;
                break;
            end
            obs_stall++;
            if (o_mem_req) begin
                if (obs_first_req < 0) obs_first_req = c;
                obs_reqc++;
                obs_be = o_mem_be; obs_we = o_mem_we;
                obs_wdata = o_mem_wdata; obs_addr = o_mem_addr;
                if (obs_reqc - 1 == waits) begin
                    i_mem_ack = 1'b1; i_mem_rdata = mrdata; i_mem_err = merr;
                end
            end
        end
        i_ma_read = 1'b0; i_ma_write = 1'b0;
        checks++;
        if (obs_done !== 1'b1) begin
            errors++;
            $display("FAIL access_done: got %b expected 1 (no ready within budget)", obs_done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        i_ma_read = 0; i_ma_write = 0; i_ma_addr = 0; i_ma_wdata = 0; i_ma_funct3 = 0;
        i_mem_ack = 0; i_mem_rdata = 0; i_mem_err = 0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        checks += 6;
        if (o_mem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", o_mem_req); end
        if (o_ma_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", o_ma_rdata); end
        if (o_misaligned !== 1'b0) begin errors++; $display("FAIL reset_mis: got %b expected 0", o_misaligned); end
        if (o_bus_err !== 1'b0) begin errors++; $display("FAIL reset_berr: got %b expected 0", o_bus_err); end
        if (o_data_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", o_data_ready); end
        if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    endtask

    task automatic test_lw();
        logic [31:0] e;
        model_rdata = 32'hDEADBEEF;
        exp_q.push_back(model_rdata);
        run_access(1, 0, 3'b010, 32'h100, 32'd0, 32'hDEADBEEF, 0, 0);
        e = exp_q.pop_front();
        checks += 7;
        if (obs_rdata !== e) begin errors++; $display("FAIL lw_rdata: got %h expected %h", obs_rdata, e); end
        if (obs_first_req !== 1) begin errors++; $display("FAIL lw_req_start: got %0d expected 1", obs_first_req); end
        if (obs_reqc !== 1) begin errors++; $display("FAIL lw_req_cycles: got %0d expected 1", obs_reqc); end
        if (obs_stall !== 2) begin errors++; $display("FAIL lw_stall: got %0d expected 2", obs_stall); end
        if (obs_addr !== 32'h100) begin errors++; $display("FAIL lw_addr: got %h expected 00000100", obs_addr); end
        if (obs_be !== 4'b1111) begin errors++; $display("FAIL lw_be: got %b expected 1111", obs_be); end
        if (obs_we !== 1'b0) begin errors++; $display("FAIL lw_we: got %b expected 0", obs_we); end
    endtask

    task automatic test_lb();
        logic [31:0] e;
        model_rdata = 32'hFFFFFF80;
        exp_q.push_back(model_rdata);
        run_access(1, 0, 3'b000, 32'h103, 32'd0, 32'h80FFFFFF, 0, 0);
        e = exp_q.pop_front();
        checks += 3;
        if (obs_rdata !== e) begin errors++; $display("FAIL lb_rdata: got %h expected %h", obs_rdata, e); end
        if (obs_be !== 4'b1000) begin errors++; $display("FAIL lb_be: got %b expected 1000", obs_be); end
        if (obs_addr !== 32'h100) begin errors++; $display("FAIL lb_addr: got %h expected 00000100", obs_addr); end
        model_rdata = 32'h00000080;
        exp_q.push_back(model_rdata);
        run_access(1, 0, 3'b100, 32'h103, 32'd0, 32'h80FFFFFF, 0, 0);
        e = exp_q.pop_front();
        checks++;
        if (obs_rdata !== e) begin errors++; $display("FAIL lbu_rdata: got %h expected %h", obs_rdata, e); end
    endtask

    task automatic test_store();
        logic [31:0] e;
        exp_q.push_back(model_rdata);
        run_access(0, 1, 3'b001, 32'h202, 32'h0000ABCD, 32'h0, 0, 3);
        e = exp_q.pop_front();
        checks += 7;
        if (obs_we !== 1'b1) begin errors++; $display("FAIL sh_we: got %b expected 1", obs_we); end
        if (obs_be !== 4'b1100) begin errors++; $display("FAIL sh_be: got %b expected 1100", obs_be); end
        if (obs_wdata !== 32'hABCDABCD) begin errors++; $display("FAIL sh_wdata: got %h expected abcdabcd", obs_wdata); end
        if (obs_addr !== 32'h200) begin errors++; $display("FAIL sh_addr: got %h expected 00000200", obs_addr); end
        if (obs_stall !== 5) begin errors++; $display("FAIL sh_stall: got %0d expected 5", obs_stall); end
        if (obs_reqc !== 4) begin errors++; $display("FAIL sh_req_cycles: got %0d expected 4", obs_reqc); end
        if (obs_rdata !== e) begin errors++; $display("FAIL sh_rdata_hold: got %h expected %h", obs_rdata, e); end
        run_access(0, 1, 3'b000, 32'h301, 32'h123456A5, 32'h0, 0, 0);
        checks += 2;
        if (obs_be !== 4'b0010) begin errors++; $display("FAIL sb_be: got %b expected 0010", obs_be); end
        if (obs_wdata !== 32'hA5A5A5A5) begin errors++; $display("FAIL sb_wdata: got %h expected a5a5a5a5", obs_wdata); end
        run_access(0, 1, 3'b010, 32'h304, 32'hCAFEF00D, 32'h0, 0, 1);
        checks += 2;
        if (obs_be !== 4'b1111) begin errors++; $display("FAIL sw_be: got %b expected 1111", obs_be); end
        if (obs_wdata !== 32'hCAFEF00D) begin errors++; $display("FAIL sw_wdata: got %h expected cafef00d", obs_wdata); end
    endtask

    task automatic test_misaligned();
        run_access(1, 0, 3'b010, 32'h101, 32'd0, 32'h0, 0, 0);
        checks += 4;
        if (obs_reqc !== 0) begin errors++; $display("FAIL mis_req: got %0d expected 0", obs_reqc); end
        if (obs_stall !== 1) begin errors++; $display("FAIL mis_stall: got %0d expected 1", obs_stall); end
        if (obs_mis !== 1'b1) begin errors++; $display("FAIL mis_flag: got %b expected 1", obs_mis); end
        if (obs_berr !== 1'b0) begin errors++; $display("FAIL mis_berr: got %b expected 0", obs_berr); end
        @(negedge clk);
        checks += 2;
        if (o_misaligned !== 1'b0) begin errors++; $display("FAIL mis_clear: got %b expected 0", o_misaligned); end
        if (dbg_state !== 2'd0) begin errors++; $display("FAIL mis_idle: got %0d expected 0", dbg_state); end
        run_access(1, 0, 3'b101, 32'h103, 32'd0, 32'h0, 0, 0);
        checks += 2;
        if (obs_reqc !== 0) begin errors++; $display("FAIL mis_hu_req: got %0d expected 0", obs_reqc); end
        if (obs_mis !== 1'b1) begin errors++; $display("FAIL mis_hu_flag: got %b expected 1", obs_mis); end
    endtask

    task automatic test_illegal();
        run_access(1, 1, 3'b010, 32'h100, 32'd0, 32'h0, 0, 0);
        checks += 4;
        if (obs_reqc !== 0) begin errors++; $display("FAIL ill_rw_req: got %0d expected 0", obs_reqc); end
        if (obs_stall !== 1) begin errors++; $display("FAIL ill_rw_stall: got %0d expected 1", obs_stall); end
        if (obs_berr !== 1'b1) begin errors++; $display("FAIL ill_rw_berr: got %b expected 1", obs_berr); end
        if (obs_mis !== 1'b0) begin errors++; $display("FAIL ill_rw_mis: got %b expected 0", obs_mis); end
        run_access(0, 1, 3'b100, 32'h100, 32'd0, 32'h0, 0, 0);
        checks += 2;
        if (obs_reqc !== 0) begin errors++; $display("FAIL ill_sbu_req: got %0d expected 0", obs_reqc); end
        if (obs_berr !== 1'b1) begin errors++; $display("FAIL ill_sbu_berr: got %b expected 1", obs_berr); end
        run_access(1, 0, 3'b011, 32'h100, 32'd0, 32'h0, 0, 0);
        checks++;
        if (obs_berr !== 1'b1) begin errors++; $display("FAIL ill_f3_berr: got %b expected 1", obs_berr); end
        @(negedge clk);
        checks++;
        if (o_bus_err !== 1'b0) begin errors++; $display("FAIL ill_clear: got %b expected 0", o_bus_err); end
    endtask

    task automatic test_timeout();
        logic [31:0] e;
        exp_q.push_back(model_rdata);
        run_access(1, 0, 3'b010, 32'h400, 32'd0, 32'h0, 0, -1);
        e = exp_q.pop_front();
        checks += 4;
        if (obs_reqc !== 4) begin errors++; $display("FAIL to_req_cycles: got %0d expected 4", obs_reqc); end
        if (obs_stall !== 5) begin errors++; $display("FAIL to_stall: got %0d expected 5", obs_stall); end
        if (obs_berr !== 1'b1) begin errors++; $display("FAIL to_berr: got %b expected 1", obs_berr); end
        if (obs_rdata !== e) begin errors++; $display("FAIL to_rdata_hold: got %h expected %h", obs_rdata, e); end
    endtask

    task automatic test_bus_err();
        logic [31:0] e;
        exp_q.push_back(model_rdata);
        run_access(1, 0, 3'b010, 32'h500, 32'd0, 32'h55555555, 1, 1);
        e = exp_q.pop_front();
        checks += 2;
        if (obs_berr !== 1'b1) begin errors++; $display("FAIL be_berr: got %b expected 1", obs_berr); end
        if (obs_rdata !== e) begin errors++; $display("FAIL be_rdata_hold: got %h expected %h", obs_rdata, e); end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  f3_tab[5];
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] word;
        logic [31:0] e;
        f3_tab[0] = 3'b000; f3_tab[1] = 3'b001; f3_tab[2] = 3'b010;
        f3_tab[3] = 3'b100; f3_tab[4] = 3'b101;
        for (int i = 0; i < 12; i++) begin
            f3   = f3_tab[$urandom_range(0, 4)];
            addr = $urandom();
            word = $urandom();
            if (f3[1:0] == 2'b01) addr[0] = 1'b0;
            if (f3 == 3'b010) addr[1:0] = 2'b00;
            model_rdata = model_load(f3, addr, word);
            exp_q.push_back(model_rdata);
            run_access(1, 0, f3, addr, 32'd0, word, 0, int'($urandom_range(0, 2)));
            e = exp_q.pop_front();
            checks++;
            if (obs_rdata !== e) begin
                errors++;
                $display("FAIL b2b_rdata[%0d]: f3=%b addr=%h got %h expected %h", i, f3, addr, obs_rdata, e);
            end
        end
    endtask

    task automatic test_reset_access();
        @(posedge clk); #1;
        i_ma_read = 1'b1; i_ma_funct3 = 3'b010; i_ma_addr = 32'h600;
        @(posedge clk); #1;
        checks++;
        if (o_mem_req !== 1'b1) begin errors++; $display("FAIL rst_acc_req: got %b expected 1", o_mem_req); end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (o_mem_req !== 1'b0) begin errors++; $display("FAIL rst_drop_req: got %b expected 0", o_mem_req); end
        i_ma_read = 1'b0;
        @(negedge clk); rst = 1'b1;
        i_mem_ack = 1'b1; i_mem_rdata = 32'h12345678; i_mem_err = 1'b0;
        model_rdata = 32'd0;
        @(negedge clk);
        i_mem_ack = 1'b0;
        checks += 5;
        if (dbg_state !== 2'd0) begin errors++; $display("FAIL rst_state: got %0d expected 0", dbg_state); end
        if (o_data_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b expected 1", o_data_ready); end
        if (o_mem_req !== 1'b0) begin errors++; $display("FAIL rst_stale_req: got %b expected 0", o_mem_req); end
        if (o_ma_rdata !== model_rdata) begin errors++; $display("FAIL rst_stale_rdata: got %h expected %h", o_ma_rdata, model_rdata); end
        if (o_bus_err !== 1'b0) begin errors++; $display("FAIL rst_stale_berr: got %b expected 0", o_bus_err); end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_lb();
        test_store();
        test_misaligned();
        test_illegal();
        test_timeout();
        test_bus_err();
        test_back_to_back();
        test_reset_access();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Memory-access responder for the MA stage of the RV32I pipeline.
- Accepts load/store requests from MA and runs a req/ack transaction on the data-memory bus.
- Handles byte/half/word lanes, sign extension, misalignment and timeout.
- Drives o_data_ready, which feeds the hazard controller's data-ready input and stalls IF/ID until the access completes.

Parameters:
- TIMEOUT, 255, cycles in ACCESS without i_mem_ack before the transaction is aborted (1..65535).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- i_ma_read  input  1  MA-stage load request.
- i_ma_write  input  1  MA-stage store request.
- i_ma_addr  input  32  byte address.
- i_ma_wdata  input  32  store data, right-aligned.
- i_ma_funct3  input  3  RV32I size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- o_ma_rdata  output  32  load result, aligned and extended.
- o_data_ready  output  1  high = no access pending; low = stall.
- o_misaligned  output  1  one-cycle pulse in DONE for a misaligned access.
- o_bus_err  output  1  one-cycle pulse in DONE for a bus error, timeout or illegal request.
- o_mem_req  output  1  bus request.
- o_mem_we  output  1  bus write.
- o_mem_addr  output  32  word address: {i_ma_addr[31:2], 2'b00}.
- o_mem_be  output  4  byte enables.
- o_mem_wdata  output  32  lane-replicated store data.
- i_mem_ack  input  1  bus completion, one-cycle pulse.
- i_mem_rdata  input  32  read word, valid with i_mem_ack.
- i_mem_err  input  1  bus error, sampled only with i_mem_ack.

Behaviour:
- Reset (rst=0, async):
  - state IDLE; o_mem_req=0; o_ma_rdata=0; o_misaligned=0; o_bus_err=0; timeout counter=0.
  - Reset during ACCESS drops o_mem_req immediately. A late ack arriving after reset is ignored.
- FSM states: IDLE, ACCESS, DONE.
- o_data_ready = (state==DONE) || (state==IDLE && !i_ma_read && !i_ma_write). The request cycle itself is therefore a stall cycle, which holds the MA inputs stable.
- IDLE with a request present:
  - Illegal request (both read and write, illegal funct3 011/110/111, or funct3 BU/HU with write): go to DONE and set the bus_err flag; no bus access.
  - Misaligned request (H/HU with addr[0]=1, or W with addr[1:0]!=0): go to DONE and set the misaligned flag; no bus access.
  - Otherwise: go to ACCESS and clear the timeout counter.
- ACCESS:
  - o_mem_req=1; o_mem_we=i_ma_write; address, be and wdata are driven from the MA inputs.
  - On i_mem_ack: go to DONE. For a read, capture the formatted data into o_ma_rdata. If i_mem_err=1, set the bus_err flag and leave o_ma_rdata unchanged.
  - Without ack: increment the counter. When the counter reaches TIMEOUT-1 without ack, go to DONE and set bus_err.
- DONE:
  - Lasts exactly one cycle; o_data_ready=1; flags visible on o_misaligned/o_bus_err.
  - Next state is IDLE, and flags clear.
  - o_ma_rdata holds its value until the next successful load.
- Latency: request at cycle T, ack at T+1 (zero wait), ready high at T+2. Each bus wait state adds one cycle.
- Byte enables and store data:
  - B: be=4'b0001<<addr[1:0], wdata={4{wdata[7:0]}}.
  - H: be=4'b0011<<{addr[1],1'b0}, wdata={2{wdata[15:0]}}.
  - W: be=4'b1111, wdata passes through.
  - Reads drive the same be pattern.
- Load formatting: select the lane by addr[1:0]. B/H sign-extend from bit 7/15; BU/HU zero-extend; W passes through.
- Bus inputs outside ACCESS are ignored.
- Misaligned or illegal requests never assert o_mem_req.

Test Plan:
1. LW addr 0x100, ack at T+1 with rdata 0xDEADBEEF -> o_mem_req high at T+1 only; o_data_ready low at T,T+1 and high at T+2; o_ma_rdata=0xDEADBEEF.
2. LB addr 0x103, rdata 0x80FFFFFF -> be=1000; o_ma_rdata=0xFFFFFF80. LBU same access -> 0x00000080.
3. SH addr 0x202, wdata 0x0000ABCD, ack after 3 waits -> o_mem_we=1, be=1100, o_mem_wdata=0xABCDABCD; o_data_ready low for 5 cycles.
4. LW addr 0x101 -> no o_mem_req; o_misaligned pulse at T+1; ready high at T+1. A read+write simultaneous request -> o_bus_err pulse at T+1, no bus activity.
5. TIMEOUT=4, LW with no ack -> req high T+1..T+4; DONE at T+5 with o_bus_err=1; o_ma_rdata unchanged.
6. rst low during ACCESS -> o_mem_req=0 same cycle; after release, state IDLE and o_data_ready=1 with no request; a stale ack is ignored.
